// File: rtl/seg_pkg.sv
// seg_pkg: shared segment constants, scan FSM states and enabled-digit search for seg_scan_sched
package seg_pkg;
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    // Lowest cyclic distance wins; an exclusive search with one enabled digit wraps back to ptr.
    function automatic logic [2:0] next_en(input logic [7:0] mask, input logic [2:0] ptr, input logic inclusive);
        logic [2:0] idx, r;
        r = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k) + {2'b00, !inclusive};
            if (mask[idx]) r = idx;
        end
        return r;
    endfunction
endpackage

// File: rtl/seg_scan_sched_if.sv
// seg_scan_sched_if: digit-enable mask and valid/ready digit write port of seg_scan_sched
interface seg_scan_sched_if;
    logic [7:0] en_mask;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    modport master (output en_mask, wr_valid, wr_addr, wr_data, input wr_ready);
    modport slave  (input en_mask, wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD to active-low {a,b,c,d,e,f,g}; codes 10-15 blank
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = bcd == 4'd0 ? SEG_0 :
                 bcd == 4'd1 ? SEG_1 :
                 bcd == 4'd2 ? SEG_2 :
                 bcd == 4'd3 ? SEG_3 :
                 bcd == 4'd4 ? SEG_4 :
                 bcd == 4'd5 ? SEG_5 :
                 bcd == 4'd6 ? SEG_6 :
                 bcd == 4'd7 ? SEG_7 :
                 bcd == 4'd8 ? SEG_8 :
                 bcd == 4'd9 ? SEG_9 : SEG_OFF;
endmodule

// File: rtl/seg_scan_sched.sv
// seg_scan_sched: 8-digit seven-segment scan with dead-time blanking and a buffered write port.
// Define SEG_LZB_EN to blank leading zeros among the enabled digits.
module seg_scan_sched
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DEAD_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_sched_if.slave   bus,
    output logic [7:0]        an,
    output logic [6:0]        seg
);
    localparam int TW = $clog2(SCAN_DIV > DEAD_CYC ? SCAN_DIV : DEAD_CYC);

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n;
    logic [TW-1:0] timer;
    logic [3:0]    dbuf [8];
    logic [3:0]    dbuf_n [8];
    logic [7:0]    sup;
    logic [6:0]    dec;
    logic          wr_fire;

    assign bus.wr_ready = !rst && (state != SHOW || bus.wr_addr != ptr);
    assign wr_fire      = bus.wr_valid && bus.wr_ready;

    // Outputs are driven from the post-edge buffer so a write landing on SHOW entry shows at once.
    always_comb begin
        dbuf_n = dbuf;
        if (wr_fire) dbuf_n[bus.wr_addr] = bus.wr_data;
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        if (bus.en_mask == 8'h00) state_n = IDLE;
        else if (state == IDLE) begin
            state_n = BLANK;
            ptr_n   = next_en(bus.en_mask, ptr, 1'b1);
        end
        else if (state == BLANK) state_n = timer == TW'(DEAD_CYC - 1) ? SHOW : BLANK;
        else if (!bus.en_mask[ptr] || timer == TW'(SCAN_DIV - 1)) begin
            state_n = BLANK;
            ptr_n   = next_en(bus.en_mask, ptr, 1'b0);
        end
    end

`ifdef SEG_LZB_EN
    logic lead;
    always_comb begin
        lead = 1'b1;
        sup  = '0;
        for (int i = 7; i >= 1; i--) begin
            sup[i] = lead && dbuf_n[i] == 4'd0;
            if (bus.en_mask[i] && dbuf_n[i] != 4'd0 && dbuf_n[i] < 4'd10) lead = 1'b0;
        end
    end
`else
    assign sup = '0;
`endif

    seg7_decode u_dec (.bcd(dbuf_n[ptr_n]), .seg(dec));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            timer <= '0;
            dbuf  <= '{default: 4'hF};
            an    <= AN_OFF;
            seg   <= SEG_OFF;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            timer <= (state_n != state || state == IDLE) ? '0 : timer + 1'b1;
            dbuf  <= dbuf_n;
            an    <= state_n == SHOW ? ~(8'd1 << ptr_n) : AN_OFF;
            seg   <= state_n == SHOW && !sup[ptr_n] ? dec : SEG_OFF;
        end
    end
endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: directed tables, corner sequences and random traffic against a cycle-count reference model
module tb_seg_scan_sched;
    localparam int SCAN = 4;
    localparam int DEAD = 2;
    localparam logic [6:0] LUT [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                        7'h00, 7'h04, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] an;
    logic [6:0] seg;
    seg_scan_sched_if bus();

    seg_scan_sched #(.SCAN_DIV(SCAN), .DEAD_CYC(DEAD)) dut (
        .clk(clk), .rst(rst), .bus(bus), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: mode 0 idle, 1 blank, 2 show; m_left = cycles still to spend in the mode.
    int m_mode, m_left, m_d;
    logic [3:0] m_buf [8];
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic last_ready;

    typedef struct {logic [7:0] mask; logic [7:0] an; logic [6:0] seg;} vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int find(input logic [7:0] mask, input int from, input int skip);
        for (int k = skip; k < skip + 8; k++)
            if (mask[(from + k) % 8]) return (from + k) % 8;
        return from;
    endfunction

    function automatic logic suppressed(input logic [7:0] mask, input int i);
`ifdef SEG_LZB_EN
        int h = -1;
        for (int j = 0; j < 8; j++)
            if (mask[j] && m_buf[j] >= 4'd1 && m_buf[j] <= 4'd9) h = j;
        return i > 0 && m_buf[i] == 4'd0 && i > h;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        logic [7:0] mk;
        logic fire;
        mk = bus.en_mask;
        if (rst) begin
            m_mode = 0; m_left = 0; m_d = 0;
            for (int i = 0; i < 8; i++) m_buf[i] = 4'hF;
        end else begin
            fire = bus.wr_valid && !(m_mode == 2 && int'(bus.wr_addr) == m_d);
            if (mk == 8'h00) m_mode = 0;
            else if (m_mode == 0) begin
                m_mode = 1; m_left = DEAD; m_d = find(mk, m_d, 0);
            end else if (m_mode == 1) begin
                if (m_left == 1) begin m_mode = 2; m_left = SCAN; end
                else m_left--;
            end else if (!mk[m_d] || m_left == 1) begin
                m_mode = 1; m_left = DEAD; m_d = find(mk, m_d, 1);
            end else m_left--;
            if (fire) m_buf[bus.wr_addr] = bus.wr_data;
        end
        e_an  = m_mode == 2 ? 8'hFF ^ (8'd1 << m_d) : 8'hFF;
        e_seg = (m_mode == 2 && !suppressed(mk, m_d)) ? LUT[m_buf[m_d]] : 7'h7F;
    endtask

    task automatic tick();
        logic er;
        #1;
        er = !rst && !(m_mode == 2 && int'(bus.wr_addr) == m_d);
        chk("wr_ready", bus.wr_ready, er);
        last_ready = er;
        @(posedge clk);
        model_step();
        #1;
        chk("an", an, e_an);
        chk("seg", seg, e_seg);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.wr_valid = 1'b0; bus.en_mask = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] d);
        bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_an(input logic [7:0] target, input string nm);
        int n = 0;
        while (an !== target && n < 40) begin tick(); n++; end
        chk(nm, an, target);
    endtask

    initial begin
        bus.en_mask = 8'h00; bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        for (int i = 0; i < 18; i++) begin
            tbl[i].mask = 8'h07;
            tbl[i].an   = (i % 6) < 2 ? 8'hFF : 8'hFF ^ (8'd1 << (i / 6));
            tbl[i].seg  = (i % 6) < 2 ? 7'h7F : LUT[i / 6 + 1];
        end

        // reset state
        do_reset();
        chk("reset_an", an, 8'hFF);
        chk("reset_seg", seg, 7'h7F);

        // three-digit scan order and dead time
        for (int i = 0; i < 3; i++) wr(3'(i), 4'(i + 1));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 18; i++) begin
                bus.en_mask = tbl[i].mask;
                tick();
                chk("tbl_an", an, tbl[i].an);
                chk("tbl_seg", seg, tbl[i].seg);
            end

        // nothing enabled: dark display, writes still accepted
        do_reset();
        for (int i = 0; i < 6; i++) begin tick(); chk("idle_an", an, 8'hFF); end
        chk("idle_ready", bus.wr_ready, 1'b1);
        wr(3'd5, 4'd7);
        bus.en_mask = 8'h20;
        wait_an(8'hDF, "idle_write_an");
        chk("idle_write_seg", seg, 7'h0F);

        // write to the shown digit stalls until blanking
        do_reset();
        wr(3'd0, 4'd1);
        bus.en_mask = 8'h01;
        wait_an(8'hFE, "stall_show");
        bus.wr_valid = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'd9;
        #1 chk("stall_ready", bus.wr_ready, 1'b0);
        for (int n = 0; n < 20 && !bus.wr_ready; n++) tick();
        chk("stall_release_an", an, 8'hFF);
        tick();
        bus.wr_valid = 1'b0;
        wait_an(8'hFE, "stall_next_an");
        chk("stall_next_seg", seg, 7'h04);

        // disabling the shown digit aborts its window
        do_reset();
        wr(3'd0, 4'd1);
        wr(3'd7, 4'd8);
        bus.en_mask = 8'h81;
        wait_an(8'h7F, "abort_d7");
        tick();
        bus.en_mask = 8'h01;
        tick(); chk("abort_blank0", an, 8'hFF);
        tick(); chk("abort_blank1", an, 8'hFF);
        tick(); chk("abort_show", an, 8'hFE);
        chk("abort_seg", seg, 7'h4F);

        // blank code
        do_reset();
        wr(3'd1, 4'hC);
        bus.en_mask = 8'h02;
        wait_an(8'hFD, "blank_an");
        chk("blank_seg", seg, 7'h7F);

        // leading zeros
        do_reset();
        wr(3'd0, 4'd5);
        for (int i = 1; i < 4; i++) wr(3'(i), 4'd0);
        bus.en_mask = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            wait_an(8'hFF ^ (8'd1 << k), "lzb_an");
`ifdef SEG_LZB_EN
            chk("lzb_seg", seg, k == 0 ? 7'h24 : 7'h7F);
`else
            chk("lzb_seg", seg, k == 0 ? 7'h24 : 7'h01);
`endif
        end

        // random traffic against the model
        do_reset();
        begin
            logic hold;
            hold = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(15) == 0)
                    case ($urandom_range(3))
                        0: bus.en_mask = 8'h00;
                        1: bus.en_mask = 8'd1 << $urandom_range(7);
                        default: bus.en_mask = 8'($urandom);
                    endcase
                if (!hold) begin
                    bus.wr_valid = 1'($urandom);
                    bus.wr_addr  = 3'($urandom);
                    bus.wr_data  = 4'($urandom);
                end
                rst = $urandom_range(299) == 0;
                tick();
                hold = bus.wr_valid && !last_ready && !rst;
            end
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
